// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: word stream into the loader and byte-write bus out to instruction memory
interface inst_mem_loader_if;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        output word_valid, word_in, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_valid, word_in, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: splits 32-bit instruction words into little-endian byte writes and holds the CPU until the image is loaded
module inst_mem_loader #(
    parameter int unsigned MEM_BYTES = 121,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    inst_mem_loader_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic [7:0]        words_loaded,
    output logic              cpu_hold
);
    typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, ERR} state_t;

    state_t      state_q;
    logic [63:0] wr_addr_q;
    logic [31:0] word_q;
    logic        last_q;
    logic [1:0]  byte_idx_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  words_q;
    logic        hold_q;

    logic [63:0] wr_addr_d;
    logic [1:0]  byte_idx_d;
    logic        fits;

    assign wr_addr_d  = wr_addr_q + 64'd4;
    assign byte_idx_d = byte_idx_q + 2'd1;
    assign fits       = wr_addr_d <= 64'(MEM_BYTES);

    assign bus.word_ready = state_q == WAIT_WORD;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow_err   = err_q;
    assign words_loaded   = words_q;
    assign cpu_hold       = hold_q;

    // Load FSM; the byte of the word currently on the bus is tracked by byte_idx_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_addr_q   <= 64'd0;
            word_q      <= 32'd0;
            last_q      <= 1'b0;
            byte_idx_q  <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= 8'd0;
            hold_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q   <= WAIT_WORD;
                        wr_addr_q <= BASE_ADDR;
                        words_q   <= 8'd0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        hold_q    <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (bus.word_valid) begin
                        if (!fits) begin
                            state_q <= ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= WRITE;
                            word_q      <= bus.word_in;
                            last_q      <= bus.word_last;
                            byte_idx_q  <= 2'd0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= wr_addr_q;
                            mem_wdata_q <= bus.word_in[7:0];
                        end
                    end
                end
                WRITE: begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_q  <= byte_idx_d;
                        mem_addr_q  <= wr_addr_q + {62'd0, byte_idx_d};
                        mem_wdata_q <= word_q[8*byte_idx_d +: 8];
                    end else begin
                        mem_we_q  <= 1'b0;
                        wr_addr_q <= wr_addr_d;
                        words_q   <= words_q + {7'd0, words_q != 8'hff};
                        if (last_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_WORD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed scenario tests against a byte-memory model fed by the loader's write bus
module tb_inst_mem_loader;
    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       overflow_err;
    logic [7:0] words_loaded;
    logic       cpu_hold;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int we_total = 0;
    logic [7:0] mem  [128];
    int         wcnt [128];

    inst_mem_loader_if bus();

    inst_mem_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .overflow_err(overflow_err),
        .words_loaded(words_loaded),
        .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: commits a byte on each rising edge with mem_we high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we === 1'b1) begin
            we_total <= we_total + 1;
            if (bus.mem_addr < 64'd128) begin
                mem[bus.mem_addr[6:0]]  <= bus.mem_wdata;
                wcnt[bus.mem_addr[6:0]] <= wcnt[bus.mem_addr[6:0]] + 1;
            end
        end
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, output int acc);
        bus.word_valid = 1'b1;
        bus.word_in    = w;
        bus.word_last  = last;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.word_ready === 1'b1) begin
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int w0;
        reset = 1'b0;
        start = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = 32'd0;
        bus.word_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
        total++; if (bus.mem_addr !== 64'd0) begin bad++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 8'd0) begin bad++; $display("FAIL reset_wdata got %h want 0", bus.mem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", overflow_err); end
        total++; if (words_loaded !== 8'd0) begin bad++; $display("FAIL reset_words got %0d want 0", words_loaded); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
        total++; if (bus.word_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", bus.word_ready); end
        reset = 1'b1;
        w0 = we_total;
        bus.word_valid = 1'b1;
        bus.word_in    = 32'hffffffff;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.word_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got %b want 0", bus.word_ready); end
        total++; if (we_total - w0 !== 0) begin bad++; $display("FAIL idle_writes got %0d want 0", we_total - w0); end
        total++; if (busy !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL idle_status got busy=%b hold=%b want busy=0 hold=1", busy, cpu_hold); end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_two_words;
        int a1, a2, w0;
        logic [7:0] exp [8];
        exp = '{8'h93, 8'h09, 8'h50, 8'h00, 8'h63, 8'h06, 8'h34, 8'h07};
        w0 = we_total;
        pulse_start;
        total++; if ({busy, cpu_hold, bus.word_ready, done} !== 4'b1110) begin bad++; $display("FAIL start_status got %b want 1110", {busy, cpu_hold, bus.word_ready, done}); end
        send_word(32'h00500993, 1'b0, a1);
        send_word(32'h07340663, 1'b1, a2);
        total++; if (a2 - a1 !== 5) begin bad++; $display("FAIL b2b_spacing got %0d want 5", a2 - a1); end
        wait_done;
        for (int i = 0; i < 8; i++) begin
            total++; if (mem[i] !== exp[i]) begin bad++; $display("FAIL two_words_byte%0d got %h want %h", i, mem[i], exp[i]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL two_words_done got %b want 1", done); end
        total++; if (words_loaded !== 8'd2) begin bad++; $display("FAIL two_words_count got %0d want 2", words_loaded); end
        total++; if ({cpu_hold, busy, bus.word_ready} !== 3'b000) begin bad++; $display("FAIL two_words_status got %b want 000", {cpu_hold, busy, bus.word_ready}); end
        total++; if (we_total - w0 !== 8) begin bad++; $display("FAIL two_words_writes got %0d want 8", we_total - w0); end
    endtask

    task automatic test_gaps;
        int a1, a2, w0;
        logic [7:0] exp [8];
        exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hd8, 8'hc7, 8'hb6, 8'ha5};
        pulse_start;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL gaps_done_drop got %b want 0", done); end
        w0 = we_total;
        send_word(32'h11223344, 1'b0, a1);
        for (int k = 1; k <= 4; k++) begin
            total++; if ({bus.word_ready, bus.mem_we} !== 2'b01) begin bad++; $display("FAIL gaps_write_cycle%0d got ready,we=%b want 01", k, {bus.word_ready, bus.mem_we}); end
            @(negedge clk);
        end
        total++; if ({bus.word_ready, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL gaps_ready_return got ready,we=%b want 10", {bus.word_ready, bus.mem_we}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if ({bus.word_ready, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL gaps_idle%0d got ready,we=%b want 10", k, {bus.word_ready, bus.mem_we}); end
        end
        send_word(32'ha5b6c7d8, 1'b1, a2);
        total++; if (a2 - a1 !== 8) begin bad++; $display("FAIL gaps_spacing got %0d want 8", a2 - a1); end
        wait_done;
        for (int i = 0; i < 8; i++) begin
            total++; if (mem[i] !== exp[i]) begin bad++; $display("FAIL gaps_byte%0d got %h want %h", i, mem[i], exp[i]); end
        end
        total++; if (we_total - w0 !== 8) begin bad++; $display("FAIL gaps_writes got %0d want 8", we_total - w0); end
        total++; if (words_loaded !== 8'd2 || done !== 1'b1) begin bad++; $display("FAIL gaps_end got words=%0d done=%b want 2,1", words_loaded, done); end
    endtask

    task automatic test_overflow;
        int acc, w0, c120, nbad;
        logic [7:0] b;
        pulse_start;
        w0 = we_total;
        c120 = wcnt[120];
        for (int i = 0; i < 30; i++) begin
            b = 8'(4 * i);
            send_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b0, acc);
        end
        send_word(32'h7b7a7978, 1'b0, acc);
        total++; if (acc < 0) begin bad++; $display("FAIL ovf_accept got %0d want cycle>=0", acc); end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", overflow_err); end
        total++; if ({cpu_hold, busy, done, bus.word_ready, bus.mem_we} !== 5'b10000) begin bad++; $display("FAIL ovf_status got %b want 10000", {cpu_hold, busy, done, bus.word_ready, bus.mem_we}); end
        total++; if (words_loaded !== 8'd30) begin bad++; $display("FAIL ovf_count got %0d want 30", words_loaded); end
        repeat (3) @(negedge clk);
        total++; if (we_total - w0 !== 120) begin bad++; $display("FAIL ovf_writes got %0d want 120", we_total - w0); end
        total++; if (wcnt[120] - c120 !== 0) begin bad++; $display("FAIL ovf_addr120 got %0d writes want 0", wcnt[120] - c120); end
        nbad = 0;
        for (int a = 0; a < 120; a++) if (mem[a] !== 8'(a)) nbad++;
        total++; if (nbad !== 0) begin bad++; $display("FAIL ovf_image got %0d wrong bytes want 0", nbad); end
        total++; if (overflow_err !== 1'b1 || bus.word_ready !== 1'b0) begin bad++; $display("FAIL ovf_sticky got err=%b ready=%b want 1,0", overflow_err, bus.word_ready); end
    endtask

    task automatic test_start_during_write;
        int acc, w0;
        logic [7:0] exp [4];
        exp = '{8'hef, 8'hbe, 8'had, 8'hde};
        pulse_start;
        total++; if (overflow_err !== 1'b0 || words_loaded !== 8'd0) begin bad++; $display("FAIL err_restart got err=%b words=%0d want 0,0", overflow_err, words_loaded); end
        w0 = we_total;
        send_word(32'hdeadbeef, 1'b1, acc);
        pulse_start;
        total++; if ({busy, bus.mem_we} !== 2'b11 || bus.mem_addr !== 64'd1) begin bad++; $display("FAIL sdw_cont got busy,we=%b addr=%0d want 11,1", {busy, bus.mem_we}, bus.mem_addr); end
        wait_done;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== exp[i]) begin bad++; $display("FAIL sdw_byte%0d got %h want %h", i, mem[i], exp[i]); end
        end
        total++; if (words_loaded !== 8'd1 || done !== 1'b1) begin bad++; $display("FAIL sdw_end got words=%0d done=%b want 1,1", words_loaded, done); end
        total++; if (we_total - w0 !== 4) begin bad++; $display("FAIL sdw_writes got %0d want 4", we_total - w0); end
    endtask

    task automatic test_reset_mid_write;
        int acc;
        int c [4];
        logic [7:0] exp [4];
        exp = '{8'hdf, 8'h9b, 8'h57, 8'h13};
        pulse_start;
        for (int i = 0; i < 4; i++) c[i] = wcnt[i];
        send_word(32'h0badf00d, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'd2 || bus.mem_wdata !== 8'had) begin bad++; $display("FAIL rmw_byte2 got we=%b addr=%0d data=%h want 1,2,ad", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        reset = 1'b0;
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rmw_we got %b want 0", bus.mem_we); end
        total++; if (bus.mem_addr !== 64'd0 || bus.mem_wdata !== 8'd0) begin bad++; $display("FAIL rmw_bus got addr=%h data=%h want 0,0", bus.mem_addr, bus.mem_wdata); end
        total++; if ({busy, done, overflow_err, cpu_hold, bus.word_ready} !== 5'b00010) begin bad++; $display("FAIL rmw_status got %b want 00010", {busy, done, overflow_err, cpu_hold, bus.word_ready}); end
        total++; if (words_loaded !== 8'd0) begin bad++; $display("FAIL rmw_words got %0d want 0", words_loaded); end
        @(negedge clk);
        reset = 1'b1;
        total++; if (wcnt[0] - c[0] !== 1 || wcnt[1] - c[1] !== 1) begin bad++; $display("FAIL rmw_kept got %0d,%0d writes want 1,1", wcnt[0] - c[0], wcnt[1] - c[1]); end
        total++; if (wcnt[2] - c[2] !== 0 || wcnt[3] - c[3] !== 0) begin bad++; $display("FAIL rmw_dropped got %0d,%0d writes want 0,0", wcnt[2] - c[2], wcnt[3] - c[3]); end
        total++; if (mem[0] !== 8'h0d || mem[1] !== 8'hf0) begin bad++; $display("FAIL rmw_mem got %h,%h want 0d,f0", mem[0], mem[1]); end
        pulse_start;
        send_word(32'h13579bdf, 1'b1, acc);
        wait_done;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== exp[i]) begin bad++; $display("FAIL reload_byte%0d got %h want %h", i, mem[i], exp[i]); end
        end
        total++; if (words_loaded !== 8'd1 || done !== 1'b1) begin bad++; $display("FAIL reload_end got words=%0d done=%b want 1,1", words_loaded, done); end
    endtask

    task automatic test_restart_done;
        int acc;
        logic [7:0] exp [4];
        exp = '{8'he3, 8'h0c, 8'h00, 8'hfc};
        pulse_start;
        total++; if ({done, cpu_hold, busy} !== 3'b011) begin bad++; $display("FAIL rst_done_start got done,hold,busy=%b want 011", {done, cpu_hold, busy}); end
        send_word(32'hfc000ce3, 1'b1, acc);
        total++; if (done !== 1'b0 || words_loaded !== 8'd0) begin bad++; $display("FAIL rst_done_mid got done=%b words=%0d want 0,0", done, words_loaded); end
        wait_done;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== exp[i]) begin bad++; $display("FAIL rst_done_byte%0d got %h want %h", i, mem[i], exp[i]); end
        end
        total++; if ({done, cpu_hold, busy} !== 3'b100 || words_loaded !== 8'd1) begin bad++; $display("FAIL rst_done_end got done,hold,busy=%b words=%0d want 100,1", {done, cpu_hold, busy}, words_loaded); end
    endtask

    initial begin
        test_reset;
        test_two_words;
        test_gaps;
        test_overflow;
        test_start_during_write;
        test_reset_mid_write;
        test_restart_done;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
